// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester, multiplier and status signals of mul_arbiter
interface mul_arbiter_if;
  logic        req0;
  logic [7:0]  a0;
  logic [7:0]  b0;
  logic        done0;
  logic [15:0] result0;
  logic        req1;
  logic [7:0]  a1;
  logic [7:0]  b1;
  logic        done1;
  logic [15:0] result1;
  logic        mul_en;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic        mul_ready;
  logic [15:0] mul_result;
  logic        busy;
  logic        mul_err;

  // master: requesters plus the multiplier; slave: the arbiter itself
  modport master (
    output req0, a0, b0, req1, a1, b1, mul_ready, mul_result,
    input  done0, result0, done1, result1, mul_en, mul_a, mul_b, busy, mul_err
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, mul_ready, mul_result,
    output done0, result0, done1, result1, mul_en, mul_a, mul_b, busy, mul_err
  );
endinterface

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one iterative signed multiplier
module mul_arbiter #(
  parameter int READY_MASK = 12,
  parameter int TIMEOUT    = 40
) (
  input logic          clk,
  input logic          reset,
  mul_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [5:0]  cyc_q;
  logic [5:0]  cyc_d;
  logic        last_q;
  logic        owner_q;
  logic        done0_q;
  logic        done1_q;
  logic        err_q;
  logic [7:0]  mul_a_q;
  logic [7:0]  mul_b_q;
  logic [15:0] result0_q;
  logic [15:0] result1_q;

  logic        armed;
  logic        hit;
  logic        timeout;
  logic        elig0;
  logic        elig1;
  logic        grant;
  logic        winner;

  assign cyc_d   = (cyc_q == 6'h3F) ? cyc_q : cyc_q + 6'd1;
  assign armed   = (cyc_q >= 6'(READY_MASK));
  assign hit     = bus.mul_ready & armed;
  assign timeout = (cyc_q == 6'(TIMEOUT));

  // Dropping enable in the same cycle ready is seen keeps the multiplier's step counter at zero.
  assign bus.mul_en = ((state_q == S_RUN) || (state_q == S_FLUSH)) && !hit;

  assign elig0  = bus.req0 & ~done0_q;
  assign elig1  = bus.req1 & ~done1_q;
  assign grant  = elig0 | elig1;
  assign winner = (elig0 && elig1) ? ~last_q : elig1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FLUSH;
      cyc_q     <= 6'd0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      mul_a_q   <= 8'd0;
      mul_b_q   <= 8'd0;
      result0_q <= 16'd0;
      result1_q <= 16'd0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_FLUSH: begin
          if (hit) begin
            state_q <= S_IDLE;
            cyc_q   <= 6'd0;
          end else if (timeout) begin
            state_q <= S_IDLE;
            cyc_q   <= 6'd0;
            err_q   <= 1'b1;
          end else begin
            cyc_q <= cyc_d;
          end
        end
        S_IDLE: begin
          if (grant) begin
            owner_q <= winner;
            last_q  <= winner;
            mul_a_q <= winner ? bus.a1 : bus.a0;
            mul_b_q <= winner ? bus.b1 : bus.b0;
            state_q <= S_RUN;
            cyc_q   <= 6'd0;
          end
        end
        S_RUN: begin
          if (hit) begin
            if (owner_q) begin
              result1_q <= bus.mul_result;
              done1_q   <= 1'b1;
            end else begin
              result0_q <= bus.mul_result;
              done0_q   <= 1'b1;
            end
            state_q <= S_DONE;
            cyc_q   <= 6'd0;
          end else if (timeout) begin
            // Hung multiplier: still answer the requester, then resynchronise with zero operands.
            if (owner_q) begin
              result1_q <= 16'd0;
              done1_q   <= 1'b1;
            end else begin
              result0_q <= 16'd0;
              done0_q   <= 1'b1;
            end
            err_q   <= 1'b1;
            mul_a_q <= 8'd0;
            mul_b_q <= 8'd0;
            state_q <= S_FLUSH;
            cyc_q   <= 6'd0;
          end else begin
            cyc_q <= cyc_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cyc_q   <= 6'd0;
        end
        default: begin
          state_q <= S_FLUSH;
          cyc_q   <= 6'd0;
        end
      endcase
    end
  end

  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.result0 = result0_q;
  assign bus.result1 = result1_q;
  assign bus.mul_a   = mul_a_q;
  assign bus.mul_b   = mul_b_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.mul_err = err_q;

endmodule
